// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline: memory-wait freeze,
// branch flush and load-use bubble, plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_Rd,
    input  logic [REG_W-1:0] IFID_Rs1,
    input  logic [REG_W-1:0] IFID_Rs2,
    input  logic             BranchTaken,
    input  logic             MemReq,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Write,
    output logic             EXMEM_Write,
    output logic             MEMWB_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             MemFault,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              advance;
    logic              branch_flush;
    logic              load_use;
    logic              mem_ready;

    // MemReady only counts while a request is actually outstanding.
    assign mem_ready = MemReq & MemReady;
    assign load_use  = IDEX_MemRead && (IDEX_Rd != '0) &&
                       ((IDEX_Rd == IFID_Rs1) || (IDEX_Rd == IFID_Rs2));

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        wait_next    = wait_cnt;
        advance      = 1'b0;
        branch_flush = 1'b0;
        MemFault     = 1'b0;
        PCWrite      = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Write  = 1'b0;
        MEMWB_Write  = 1'b0;
        IFID_Flush   = 1'b0;
        IDEX_Flush   = 1'b0;

        if (!Reset) begin
            unique case (state)
                RUN: begin
                    if (MemReq && !MemReady) begin
                        state_next = MEM_WAIT;
                        wait_next  = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        advance    = 1'b1;
                        state_next = RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_next = FAULT;
                    end else begin
                        wait_next = wait_cnt + WAIT_W'(1);
                    end
                end
                FAULT: begin
                    MemFault = 1'b1;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end

        // Branch outranks load-use; both only act when the pipeline advances.
        if (advance) begin
            PCWrite     = 1'b1;
            IFID_Write  = 1'b1;
            IDEX_Write  = 1'b1;
            EXMEM_Write = 1'b1;
            MEMWB_Write = 1'b1;
            if (BranchTaken) begin
                branch_flush = 1'b1;
                IFID_Flush   = 1'b1;
                IDEX_Flush   = 1'b1;
            end else if (load_use) begin
                PCWrite    = 1'b0;
                IFID_Write = 1'b0;
                IDEX_Flush = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= RUN;
            wait_cnt   <= '0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if ((state != FAULT) && !PCWrite && (StallCount != '1)) begin
                StallCount <= StallCount + CNT_W'(1);
            end
            if (branch_flush && (FlushCount != '1)) begin
                FlushCount <= FlushCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a cycle-level behavioural model is
// compared every cycle, with hand-computed literal checks pinning the model.
module tb_pipeline_hazard_ctrl;

    localparam int RW  = 4;
    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          IDEX_MemRead;
    logic [RW-1:0] IDEX_Rd, IFID_Rs1, IFID_Rs2;
    logic          BranchTaken, MemReq, MemReady;
    logic          PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write;
    logic          IFID_Flush, IDEX_Flush, MemFault;
    logic [CW-1:0] StallCount, FlushCount;

    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(.REG_W(RW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK(CLK), .Reset(Reset),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_Rd(IDEX_Rd),
        .IFID_Rs1(IFID_Rs1), .IFID_Rs2(IFID_Rs2),
        .BranchTaken(BranchTaken), .MemReq(MemReq), .MemReady(MemReady),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
        .EXMEM_Write(EXMEM_Write), .MEMWB_Write(MEMWB_Write),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
        .MemFault(MemFault), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 CLK = ~CLK;

    // {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write, IFID_Flush, IDEX_Flush}
    wire [6:0] ctl = {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
                      IFID_Flush, IDEX_Flush};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a stall streak counts consecutive frozen cycles (the request cycle
    // plus every waiting cycle); the fault is raised once the streak exceeds
    // the request cycle plus TO wait cycles.
    bit fault_m   = 1'b0;
    int streak_m  = 0;
    int stalls_m  = 0;
    int flushes_m = 0;

    always @(negedge CLK) begin
        logic       lu, frozen, br, lu_stall;
        logic [6:0] exp_ctl;
        logic       exp_fault;
        lu = IDEX_MemRead && (IDEX_Rd != 0) && (IDEX_Rd == IFID_Rs1 || IDEX_Rd == IFID_Rs2);
        frozen = 1'b0; br = 1'b0; lu_stall = 1'b0;
        exp_ctl = 7'b0; exp_fault = 1'b0;
        if (!Reset && fault_m) begin
            exp_fault = 1'b1;
        end else if (!Reset) begin
            frozen   = (streak_m > 0) ? !(MemReq && MemReady) : (MemReq && !MemReady);
            br       = !frozen && BranchTaken;
            lu_stall = !frozen && !BranchTaken && lu;
            exp_ctl  = {!frozen && !lu_stall, !frozen && !lu_stall, !frozen, !frozen, !frozen,
                        br, br || lu_stall};
        end
        check("model_ctl", 32'(ctl), 32'(exp_ctl));
        check("model_fault", 32'(MemFault), 32'(exp_fault));
        check("model_stall_cnt", 32'(StallCount), 32'(stalls_m));
        check("model_flush_cnt", 32'(FlushCount), 32'(flushes_m));

        if (Reset) begin
            fault_m = 1'b0; streak_m = 0; stalls_m = 0; flushes_m = 0;
        end else if (!fault_m) begin
            if (!exp_ctl[6] && stalls_m < SAT) stalls_m++;
            if (br && flushes_m < SAT) flushes_m++;
            if (frozen) begin
                streak_m++;
                if (streak_m == TO + 1) fault_m = 1'b1;
            end else begin
                streak_m = 0;
            end
        end
    end

    task automatic cyc(input logic rst, input logic mr, input logic [RW-1:0] rd,
                       input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic br, input logic req, input logic rdy);
        @(posedge CLK);
        #1;
        Reset = rst; IDEX_MemRead = mr; IDEX_Rd = rd; IFID_Rs1 = rs1; IFID_Rs2 = rs2;
        BranchTaken = br; MemReq = req; MemReady = rdy;
        @(negedge CLK);
        #1;
    endtask

    initial begin
        Reset = 1'b1; IDEX_MemRead = 1'b1; IDEX_Rd = '1; IFID_Rs1 = '1; IFID_Rs2 = '1;
        BranchTaken = 1'b1; MemReq = 1'b1; MemReady = 1'b1;
        @(negedge CLK);
        #1;
        check("reset1_ctl", 32'(ctl), 32'h0);
        check("reset1_fault", 32'(MemFault), 32'h0);
        cyc(1, 1, 4'hF, 4'hF, 4'hF, 1, 1, 1);
        check("reset2_ctl", 32'(ctl), 32'h0);
        check("reset2_stall", 32'(StallCount), 32'h0);
        check("reset2_flush", 32'(FlushCount), 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("run_ctl", 32'(ctl), 32'h7C);

        // Memory wait: three not-ready cycles, then ready.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
            check("memwait_freeze", 32'(ctl), 32'h0);
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        check("memwait_ready_ctl", 32'(ctl), 32'h7C);
        check("memwait_stall_cnt", 32'(StallCount), 32'd3);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        check("ready_no_req", 32'(ctl), 32'h7C);

        // Load-use via Rs2, bubble, Rd=0, load-use via Rs1.
        cyc(0, 1, 5, 0, 5, 0, 0, 0);
        check("loaduse_rs2", 32'(ctl), 32'h1D);
        cyc(0, 0, 5, 0, 5, 0, 0, 0);
        check("loaduse_after", 32'(ctl), 32'h7C);
        check("loaduse_stall_cnt", 32'(StallCount), 32'd4);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        check("loaduse_rd0", 32'(ctl), 32'h7C);
        cyc(0, 1, 3, 3, 7, 0, 0, 0);
        check("loaduse_rs1", 32'(ctl), 32'h1D);

        // Priority: branch over load-use, memory stall over both.
        cyc(0, 1, 5, 0, 5, 1, 0, 0);
        check("prio_branch", 32'(ctl), 32'h7F);
        cyc(0, 1, 5, 0, 5, 1, 1, 0);
        check("prio_mem", 32'(ctl), 32'h0);
        check("prio_flush_cnt", 32'(FlushCount), 32'd1);
        cyc(0, 1, 5, 0, 5, 1, 1, 1);
        check("wait_ready_branch", 32'(ctl), 32'h7F);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("prio_stall_cnt", 32'(StallCount), 32'd6);
        check("prio_flush_cnt2", 32'(FlushCount), 32'd2);

        // Flush counter saturation.
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("flush_sat", 32'(FlushCount), 32'd15);

        // Timeout: request cycle plus TO waiting cycles without ready.
        for (int i = 0; i < TO + 1; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        check("fault_set", 32'(MemFault), 32'h1);
        check("fault_ctl", 32'(ctl), 32'h0);
        cyc(0, 1, 5, 5, 5, 1, 0, 0);
        check("fault_sticky", 32'(MemFault), 32'h1);
        check("fault_stall_hold", 32'(StallCount), 32'd11);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        check("fault_reset_fault", 32'(MemFault), 32'h0);
        check("fault_reset_ctl", 32'(ctl), 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("after_reset_run", 32'(ctl), 32'h7C);
        check("after_reset_stall", 32'(StallCount), 32'd0);

        // Reset aborts a wait in progress.
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("abort_wait_run", 32'(ctl), 32'h7C);

        // Ready on the last permitted wait cycle is honoured.
        for (int i = 0; i < TO; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        check("last_ready_ctl", 32'(ctl), 32'h7C);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("last_ready_nofault", 32'(MemFault), 32'h0);
        check("last_ready_stall", 32'(StallCount), 32'd4);

        // Stall counter saturation.
        for (int i = 0; i < 20; i++) cyc(0, 1, 9, 9, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("stall_sat", 32'(StallCount), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 16-bit five-stage pipeline. Drives write enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, plus bubble/flush strobes for the front-end registers. Resolves three hazard classes: multi-cycle data-memory access, load-use dependency and taken branch/jump. Keeps saturating stall and flush counters for performance debug.

## Interface
- REG_W, 4: register-index width.
- MEM_TIMEOUT, 64: maximum number of MEM_WAIT cycles before the block declares a fault.
- CNT_W, 16: width of each performance counter.

- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  reset, synchronous, active-high.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_Rd  in  REG_W  destination register of the instruction in EX.
- IFID_Rs1, IFID_Rs2  in  REG_W  source registers of the instruction in ID.
- BranchTaken  in  1  EX resolved a taken branch or jump this cycle.
- MemReq  in  1  MEM stage is issuing a data access (OMemRead | OMemWrite of EX/MEM).
- MemReady  in  1  data memory completes the access this cycle.
- PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write  out  1  stage register enables.
- IFID_Flush, IDEX_Flush  out  1  load zeros (bubble) into that register at the next edge.
- MemFault  out  1  sticky memory timeout indication.
- StallCount, FlushCount  out  CNT_W  saturating event counters.

## Operation
- State register with three states: RUN, MEM_WAIT, FAULT. The outputs are combinational from the state and the inputs. State, wait counter and perf counters are registered.
- Default in RUN: all enables 1, all flushes 0.
- Priority when several hazards occur in the same cycle: memory stall > branch flush > load-use stall.
- Memory stall:
  - Condition: RUN with MemReq=1 and MemReady=0.
  - Response: all five enables 0 and both flushes 0 in that cycle. Next state is MEM_WAIT and the wait counter is cleared.
- MEM_WAIT:
  - MemReady=0: all enables 0, wait counter increments.
  - MemReady=1: all enables 1 in that cycle, so the pipeline advances. Next state is RUN.
  - Branch and load-use conditions present in a MEM_WAIT cycle with MemReady=1 are evaluated normally in that same cycle.
- Timeout: the wait counter reaching MEM_TIMEOUT-1 with MemReady still 0 moves the block to FAULT on the next edge.
- FAULT: all enables 0, all flushes 0, MemFault=1. The block leaves FAULT only on Reset.
- Branch flush:
  - Condition: BranchTaken=1 with no memory stall.
  - Response: IFID_Flush=1, IDEX_Flush=1, all enables 1. The PC loads the target.
- Load-use stall:
  - Condition: IDEX_MemRead=1, IDEX_Rd≠0, and (IDEX_Rd==IFID_Rs1 or IDEX_Rd==IFID_Rs2), with no memory stall and no branch.
  - Response: PCWrite=0, IFID_Write=0, IDEX_Flush=1; EXMEM_Write=1, MEMWB_Write=1.
  - Lasts exactly one cycle, because the bubble clears IDEX_MemRead.
- StallCount increments by 1 per cycle in which PCWrite=0 outside Reset and FAULT. It saturates at 2^CNT_W−1.
- FlushCount increments by 1 per branch-flush cycle. It saturates at 2^CNT_W−1.

## Timing
- Reset:
  - While Reset=1: state RUN, wait counter 0, StallCount 0, FlushCount 0, MemFault 0. All enables 0 and all flushes 0.
  - The stage registers self-clear on the same Reset.
  - Reset has priority in every state, including FAULT, and it aborts a MEM_WAIT in progress.
- Latency:
  - Hazard response is zero-cycle (combinational) relative to the triggering inputs.
  - State changes take effect at the next rising edge.
- Handshake: MemReq must stay asserted and stable through MEM_WAIT, because the EX/MEM register is frozen. MemReady is sampled only while MemReq=1; MemReady without MemReq is ignored.
- Boundaries:
  - MemReady=1 on the same cycle as the request gives no stall and no state change.
  - Ready arriving on exactly the last permitted wait cycle (counter = MEM_TIMEOUT-1) is honoured: next state RUN, not FAULT.
  - Counters saturate and never wrap.

## Test plan
- Reset behaviour: assert Reset 2 cycles with all inputs 1 → all enables 0, flushes 0, counters 0, MemFault 0. Release → RUN with all enables 1.
- Memory wait: MemReq=1, MemReady low 3 cycles then high → enables 0 for 3 cycles, 1 on the 4th. StallCount=3. State returns to RUN.
- Load-use stall: IDEX_MemRead=1, IDEX_Rd=5, IFID_Rs2=5 → one cycle of PCWrite=0, IFID_Write=0, IDEX_Flush=1. With IDEX_Rd=0 → no stall.
- Hazard priority: BranchTaken=1 together with a matching load-use condition → IFID_Flush=1, IDEX_Flush=1, PCWrite=1, FlushCount+1. Then add MemReq=1 with MemReady=0 to the same cycle → full freeze and no flush.
- Timeout fault:
  - MEM_TIMEOUT=4, MemReady held 0 → FAULT entered after 4 wait cycles, MemFault=1 and stays set when MemReady later goes 1. Reset clears it.
  - Ready on wait cycle 4 → RUN.
- Counter saturation: CNT_W=4 with 20 branch flushes → FlushCount holds at 15.
